control_cmd_dumpframe: RTL and testbench
========================================

CONTROL_CMD_DUMPFRAME -- requirements
Module: control_cmd_dumpframe

Interface
REQ-001 Parameter RAM_LATENCY, default 1, cycles from ram_read_enable to valid ram_data_in; legal values 1 or 2.
REQ-002 clk  input  1  sole clock; all state changes on posedge clk.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  single-cycle request to dump the whole framebuffer.
REQ-005 abort  input  1  synchronous cancel of a dump in progress.
REQ-006 ram_addr  output  types::fb_addr_t  framebuffer read address (row, col, pixel).
REQ-007 ram_read_enable  output  1  one-cycle read strobe.
REQ-008 ram_data_in  input  8  read data, valid RAM_LATENCY cycles after the strobe.
REQ-009 tx_data  output  8  byte to the serial transmitter.
REQ-010 tx_valid  output  1  tx_data valid.
REQ-011 tx_ready  input  1  transmitter accepts tx_data this cycle.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse after the last byte is accepted.

Function
REQ-014 The FSM SHALL have states IDLE, FETCH, WAIT, SEND and DONE.
REQ-015 In IDLE, start SHALL load ram_addr = {row 0, col 0, pixel BYTES_PER_PIXEL-1} and enter FETCH.
REQ-016 In IDLE, start low SHALL hold the FSM in IDLE.
REQ-017 While busy, start SHALL be ignored.
REQ-018 In FETCH, ram_read_enable SHALL be high for exactly that one cycle; the FSM then enters WAIT.
REQ-019 In WAIT, a latency counter SHALL capture ram_data_in into tx_data exactly RAM_LATENCY cycles after the strobe.
REQ-020 On that capture, tx_valid SHALL be set and the FSM SHALL enter SEND.
REQ-021 ram_addr SHALL remain stable from the FETCH cycle until the byte has been captured.
REQ-022 In SEND, tx_valid and tx_data SHALL hold unchanged until tx_valid && tx_ready.
REQ-023 On that handshake, tx_valid SHALL clear in the same edge and the address SHALL advance.
REQ-024 Address advance order: pixel counts down from BYTES_PER_PIXEL-1 to 0.
REQ-025 When pixel is 0, pixel SHALL reload to BYTES_PER_PIXEL-1 and col SHALL increment.
REQ-026 When col is PIXEL_WIDTH-1 on that step, col SHALL wrap to 0 and row SHALL increment.
REQ-027 The byte order SHALL match the frame-load command, so a dump re-sent as a frame load reproduces the framebuffer.
REQ-028 After a non-final handshake, the FSM SHALL return to FETCH.
REQ-029 The final byte is row PIXEL_HEIGHT-1, col PIXEL_WIDTH-1, pixel 0; its handshake SHALL enter DONE with no address advance.
REQ-030 In DONE, done SHALL be high for one cycle, and the FSM SHALL then enter IDLE with ram_addr cleared to 0.
REQ-031 A full dump SHALL emit exactly PIXEL_WIDTH*PIXEL_HEIGHT*BYTES_PER_PIXEL bytes.
REQ-032 Each byte SHALL take at least RAM_LATENCY+2 cycles from FETCH entry to handshake.
REQ-033 tx_ready held high SHALL give a throughput of exactly one byte per RAM_LATENCY+2 cycles.
REQ-034 abort while busy SHALL, on the next edge, enter IDLE with tx_valid=0, ram_read_enable=0 and done=0.
REQ-035 abort is the only permitted withdrawal of tx_valid without a handshake.
REQ-036 abort has priority over a simultaneous tx_ready handshake, and that byte counts as not sent.
REQ-037 abort in IDLE SHALL have no effect, and abort together with start in IDLE SHALL stay in IDLE.
REQ-038 tx_ready while tx_valid=0 SHALL be ignored.
REQ-039 Row, col and pixel increments SHALL be computed at the width of their own typedefs, with no carries into neighbouring fields.

Reset
REQ-040 Asserting reset SHALL immediately force IDLE, ram_addr=0, ram_read_enable=0, tx_data=0, tx_valid=0, busy=0, done=0 and latency counter=0.
REQ-041 Reset asserted mid-dump SHALL discard progress, and the next start SHALL restart at row 0, col 0.
REQ-042 Reset deassertion SHALL be synchronised externally; the block SHALL not sample start on the deasserting edge.

Structure
REQ-043 types::fb_addr_t, row_addr_t, col_addr_t and pixel_addr_t, and params::PIXEL_WIDTH, PIXEL_HEIGHT and BYTES_PER_PIXEL SHALL come from the shared packages.
REQ-044 The FSM state enum SHALL stay local to the module.
REQ-045 The row/col/pixel address stepper SHALL be one sub-module, fb_addr_stepper, shared with the frame-load command: step input, last output.

Verification
REQ-046 With tx_ready held high, a start pulse SHALL produce tx_valid exactly W*H*BPP times, with bytes equal to a preloaded framebuffer in load order, followed by one done pulse.
REQ-047 With BPP=2, the first three read addresses SHALL be (0,0,1), (0,0,0), (0,1,1), and col W-1 pixel 0 SHALL be followed by (1,0,1).
REQ-048 With tx_ready low for 10 cycles during byte 5, tx_data and tx_valid SHALL stay stable and byte 6 SHALL not be fetched before the handshake.
REQ-049 Abort asserted on the cycle of the byte 3 handshake SHALL give IDLE, tx_valid=0 and no done; a new start SHALL then re-emit from byte 0.
REQ-050 Reset asserted in WAIT SHALL clear all outputs asynchronously before the next edge, and a start pulse applied while busy SHALL not change the byte count.
REQ-051 RAM_LATENCY=2 SHALL capture data 2 cycles after ram_read_enable, with a spacing of 4 cycles per byte when tx_ready is held high.

Source files
------------

// File: rtl/control_cmd_dumpframe_pkg.sv
// Shared framebuffer geometry, address types and dump-command constants.
// params and types are the codebase-wide packages that the frame-load and
// frame-dump commands both use.
// control_cmd_dumpframe_pkg holds the constants local to the dump command.
package params;
  localparam int PIXEL_WIDTH     = 4;
  localparam int PIXEL_HEIGHT    = 3;
  localparam int BYTES_PER_PIXEL = 2;
endpackage

package types;
  import params::*;

  localparam int ROW_W = (PIXEL_HEIGHT > 1)    ? $clog2(PIXEL_HEIGHT)    : 1;
  localparam int COL_W = (PIXEL_WIDTH > 1)     ? $clog2(PIXEL_WIDTH)     : 1;
  localparam int PIX_W = (BYTES_PER_PIXEL > 1) ? $clog2(BYTES_PER_PIXEL) : 1;

  typedef logic [ROW_W-1:0] row_addr_t;
  typedef logic [COL_W-1:0] col_addr_t;
  typedef logic [PIX_W-1:0] pixel_addr_t;

  typedef struct packed {
    row_addr_t   row;
    col_addr_t   col;
    pixel_addr_t pixel;
  } fb_addr_t;

  localparam col_addr_t   COL_LAST = col_addr_t'(PIXEL_WIDTH - 1);
  localparam pixel_addr_t PIX_LAST = pixel_addr_t'(BYTES_PER_PIXEL - 1);

  // First byte of a frame: top-left pixel, most significant byte first.
  localparam fb_addr_t ADDR_FIRST = '{row: '0, col: '0, pixel: PIX_LAST};
  // Last byte of a frame: bottom-right pixel, least significant byte.
  localparam fb_addr_t ADDR_FINAL = '{row:   row_addr_t'(PIXEL_HEIGHT - 1),
                                      col:   COL_LAST,
                                      pixel: '0};
endpackage

package control_cmd_dumpframe_pkg;
  import params::*;

  localparam int DATA_W     = 8;
  localparam int LAT_W      = 2;
  localparam int DUMP_BYTES = PIXEL_WIDTH * PIXEL_HEIGHT * BYTES_PER_PIXEL;
endpackage

// File: rtl/control_cmd_dumpframe_if.sv
// Command, framebuffer-read and transmitter signals of the dump command.
// master is the dump engine; slave is whatever drives it (control, RAM, UART).
interface control_cmd_dumpframe_if;
  import types::*;
  import control_cmd_dumpframe_pkg::*;

  logic              start;
  logic              abort;
  logic              busy;
  logic              done;
  fb_addr_t          ram_addr;
  logic              ram_read_enable;
  logic [DATA_W-1:0] ram_data_in;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (
    input  start, abort, ram_data_in, tx_ready,
    output busy, done, ram_addr, ram_read_enable, tx_data, tx_valid
  );

  modport slave (
    output start, abort, ram_data_in, tx_ready,
    input  busy, done, ram_addr, ram_read_enable, tx_data, tx_valid
  );
endinterface

// File: rtl/control_cmd_dumpframe_stepper.sv
// Row/col/pixel framebuffer address walker, shared by the frame-load and
// frame-dump commands so both traverse the frame in the same byte order:
// pixel counts down, then col counts up, then row counts up.
// Each field steps at its own width; no carry spills into a neighbour.
module fb_addr_stepper
  import params::*;
  import types::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     init,
  input  logic     clear,
  input  logic     step,
  output fb_addr_t addr,
  output logic     last
);

  fb_addr_t addr_q;
  fb_addr_t addr_nxt;

  // Address that follows addr_q in frame order.
  always_comb begin
    addr_nxt = addr_q;
    if (addr_q.pixel != pixel_addr_t'(0)) begin
      addr_nxt.pixel = addr_q.pixel - pixel_addr_t'(1);
    end else begin
      addr_nxt.pixel = PIX_LAST;
      if (addr_q.col == COL_LAST) begin
        addr_nxt.col = '0;
        addr_nxt.row = addr_q.row + row_addr_t'(1);
      end else begin
        addr_nxt.col = addr_q.col + col_addr_t'(1);
      end
    end
  end

  // Address register: clear wins over init, init over step.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q <= '0;
    end else if (clear) begin
      addr_q <= '0;
    end else if (init) begin
      addr_q <= ADDR_FIRST;
    end else if (step) begin
      addr_q <= addr_nxt;
    end
  end

  assign addr = addr_q;
  assign last = (addr_q == ADDR_FINAL);

endmodule

// File: rtl/control_cmd_dumpframe.sv
// Frame dump command: reads every framebuffer byte in frame-load order and
// hands each one to the serial transmitter over a valid/ready handshake.
// One byte costs a FETCH cycle, RAM_LATENCY WAIT cycles and at least one
// SEND cycle. abort returns to IDLE on the next edge, dropping any byte
// still on offer.
module control_cmd_dumpframe
  import params::*;
  import types::*;
  import control_cmd_dumpframe_pkg::*;
#(
  parameter int RAM_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  control_cmd_dumpframe_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    SEND,
    DONE
  } state_t;

  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RAM_LATENCY - 1);

  state_t            state_q;
  state_t            state_d;
  logic [LAT_W-1:0]  lat_q;
  logic              armed_q;
  logic [DATA_W-1:0] tx_data_q;
  logic              tx_valid_q;
  logic              addr_init;
  logic              addr_clear;
  logic              addr_step;
  logic              addr_last;
  fb_addr_t          addr_q;
  logic              handshake;
  logic              lat_hit;
  logic              abort_busy;
  logic              capture;

  assign handshake  = tx_valid_q && bus.tx_ready;
  assign lat_hit    = (state_q == WAIT) && (lat_q == LAT_LAST);
  assign abort_busy = bus.abort && (state_q != IDLE);
  assign capture    = lat_hit && !abort_busy;

  fb_addr_stepper u_stepper (
    .clk   (clk),
    .reset (reset),
    .init  (addr_init),
    .clear (addr_clear),
    .step  (addr_step),
    .addr  (addr_q),
    .last  (addr_last)
  );

  // Next state and address-walker controls; abort overrides everything.
  always_comb begin
    state_d    = state_q;
    addr_init  = 1'b0;
    addr_clear = 1'b0;
    addr_step  = 1'b0;
    case (state_q)
      IDLE: begin
        // armed_q keeps the edge that releases reset from starting a dump.
        if (bus.start && armed_q && !bus.abort) begin
          state_d   = FETCH;
          addr_init = 1'b1;
        end
      end
      FETCH: state_d = WAIT;
      WAIT: begin
        if (lat_hit) state_d = SEND;
      end
      SEND: begin
        if (handshake) begin
          if (addr_last) begin
            state_d = DONE;
          end else begin
            state_d   = FETCH;
            addr_step = 1'b1;
          end
        end
      end
      DONE: begin
        state_d    = IDLE;
        addr_clear = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (abort_busy) begin
      state_d    = IDLE;
      addr_init  = 1'b0;
      addr_step  = 1'b0;
      addr_clear = 1'b1;
    end
  end

  // State register plus the flag that arms start one edge after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      armed_q <= 1'b1;
    end
  end

  // Counts WAIT cycles since the read strobe; idles at zero elsewhere.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lat_q <= '0;
    end else if ((state_q == WAIT) && !lat_hit && !abort_busy) begin
      lat_q <= lat_q + LAT_W'(1);
    end else begin
      lat_q <= '0;
    end
  end

  // Transmit byte register: load on capture, drop valid on handshake/abort.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
    end else if (capture) begin
      tx_data_q  <= bus.ram_data_in;
      tx_valid_q <= 1'b1;
    end else if (abort_busy || handshake) begin
      tx_valid_q <= 1'b0;
    end
  end

  assign bus.ram_addr        = addr_q;
  assign bus.ram_read_enable = (state_q == FETCH);
  assign bus.tx_data         = tx_data_q;
  assign bus.tx_valid        = tx_valid_q;
  assign bus.busy            = (state_q != IDLE);
  assign bus.done            = (state_q == DONE);

endmodule

// File: tb/tb_control_cmd_dumpframe.sv
// Directed bench for control_cmd_dumpframe: one instance with RAM_LATENCY=1
// and one with RAM_LATENCY=2, each fed by a small framebuffer RAM model that
// drives 8'hEE outside its single valid data cycle.
module tb_control_cmd_dumpframe;
  import params::*;
  import types::*;
  import control_cmd_dumpframe_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   vectors     = 0;
  int   miscompares = 0;
  int   cycle       = 0;

  control_cmd_dumpframe_if a_if ();
  control_cmd_dumpframe_if b_if ();

  control_cmd_dumpframe #(.RAM_LATENCY(1)) dut_a (.clk(clk), .reset(reset), .bus(a_if));
  control_cmd_dumpframe #(.RAM_LATENCY(2)) dut_b (.clk(clk), .reset(reset), .bus(b_if));

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // Framebuffer contents: byte k of the frame in load order.
  function automatic logic [7:0] exp_byte(input int k);
    int t;
    t = k * 37 + 11;
    return t[7:0];
  endfunction

  function automatic fb_addr_t mk_addr(input int r, input int c, input int p);
    fb_addr_t a;
    a.row   = row_addr_t'(r);
    a.col   = col_addr_t'(c);
    a.pixel = pixel_addr_t'(p);
    return a;
  endfunction

  function automatic logic [7:0] mem_at(input fb_addr_t a);
    return exp_byte((int'(a.row) * PIXEL_WIDTH + int'(a.col)) * BYTES_PER_PIXEL
                    + (BYTES_PER_PIXEL - 1 - int'(a.pixel)));
  endfunction

  // RAM models
  logic [7:0] a_rd1, b_rd1, b_rd2;
  always @(posedge clk) a_rd1 <= a_if.ram_read_enable ? mem_at(a_if.ram_addr) : 8'hEE;
  always @(posedge clk) begin
    b_rd1 <= b_if.ram_read_enable ? mem_at(b_if.ram_addr) : 8'hEE;
    b_rd2 <= b_rd1;
  end
  assign a_if.ram_data_in = a_rd1;
  assign b_if.ram_data_in = b_rd2;

  // Monitors
  logic [7:0] a_rx[$];
  logic [7:0] b_rx[$];
  fb_addr_t   a_rd[$];
  int         a_rdc[$];
  int         b_rdc[$];
  int         a_done = 0;
  int         b_done = 0;

  always @(negedge clk) begin
    if (reset) begin
      if (a_if.tx_valid && a_if.tx_ready && !a_if.abort) a_rx.push_back(a_if.tx_data);
      if (a_if.ram_read_enable) begin
        a_rd.push_back(a_if.ram_addr);
        a_rdc.push_back(cycle);
      end
      if (a_if.done) a_done = a_done + 1;
      if (b_if.tx_valid && b_if.tx_ready && !b_if.abort) b_rx.push_back(b_if.tx_data);
      if (b_if.ram_read_enable) b_rdc.push_back(cycle);
      if (b_if.done) b_done = b_done + 1;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle(input bit use_b, input int budget, output bit ok);
    int t = 0;
    while (((use_b ? b_if.busy : a_if.busy) !== 1'b0) && t < budget) begin
      tick(1);
      t++;
    end
    ok = ((use_b ? b_if.busy : a_if.busy) === 1'b0);
  endtask

  task automatic wait_valid(input int k);
    int t = 0;
    while (a_if.tx_valid !== 1'b1 && t < 20) begin
      tick(1);
      t++;
    end
    vectors++;
    if (a_if.tx_valid !== 1'b1)
      begin miscompares++; $display("FAIL wait_valid byte %0d: tx_valid=%b after 20 cycles, required 1", k, a_if.tx_valid); end
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    #2;
    vectors++;
    if ({a_if.busy, a_if.done, a_if.tx_valid, a_if.ram_read_enable} !== 4'b0000)
      begin miscompares++; $display("FAIL reset_ctrl: busy/done/valid/re=%b required 0000",
        {a_if.busy, a_if.done, a_if.tx_valid, a_if.ram_read_enable}); end
    vectors++;
    if (a_if.tx_data !== 8'h00)
      begin miscompares++; $display("FAIL reset_tx_data: got %h required 00", a_if.tx_data); end
    vectors++;
    if (a_if.ram_addr !== mk_addr(0, 0, 0))
      begin miscompares++; $display("FAIL reset_ram_addr: got %h required 0", a_if.ram_addr); end
    vectors++;
    if ({b_if.busy, b_if.done, b_if.tx_valid, b_if.ram_read_enable} !== 4'b0000)
      begin miscompares++; $display("FAIL reset_ctrl_b: got %b required 0000",
        {b_if.busy, b_if.done, b_if.tx_valid, b_if.ram_read_enable}); end
    @(posedge clk);
    #1 reset = 1'b1;
    tick(3);
    vectors++;
    if (a_if.busy !== 1'b0)
      begin miscompares++; $display("FAIL idle_hold: busy=%b required 0", a_if.busy); end
    a_if.start = 1'b1;
    a_if.abort = 1'b1;
    tick(1);
    a_if.start = 1'b0;
    a_if.abort = 1'b0;
    tick(1);
    vectors++;
    if (a_if.busy !== 1'b0 || a_if.ram_addr !== mk_addr(0, 0, 0))
      begin miscompares++; $display("FAIL abort_start_idle: busy=%b addr=%h required 0 0", a_if.busy, a_if.ram_addr); end
  endtask

  task automatic test_full_dump();
    int rx0, rd0, dn0;
    bit ok;
    int ai[5];
    fb_addr_t ae[5];
    rx0 = a_rx.size(); rd0 = a_rd.size(); dn0 = a_done;
    ai = '{0, 1, 2, 7, 8};
    ae[0] = mk_addr(0, 0, 1);
    ae[1] = mk_addr(0, 0, 0);
    ae[2] = mk_addr(0, 1, 1);
    ae[3] = mk_addr(0, PIXEL_WIDTH - 1, 0);
    ae[4] = mk_addr(1, 0, 1);
    a_if.tx_ready = 1'b1;
    a_if.start = 1'b1;
    tick(1);
    a_if.start = 1'b0;
    vectors++;
    if (a_if.busy !== 1'b1 || a_if.ram_read_enable !== 1'b1)
      begin miscompares++; $display("FAIL start_fetch: busy=%b re=%b required 1 1", a_if.busy, a_if.ram_read_enable); end
    tick(10);
    a_if.start = 1'b1;
    tick(1);
    a_if.start = 1'b0;
    wait_idle(1'b0, 400, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL full_timeout: busy=%b after 400 cycles, required 0", a_if.busy); end
    tick(2);
    vectors++;
    if (a_rx.size() - rx0 != DUMP_BYTES)
      begin miscompares++; $display("FAIL full_count: got %0d bytes required %0d", a_rx.size() - rx0, DUMP_BYTES); end
    for (int k = 0; k < DUMP_BYTES && k < a_rx.size() - rx0; k++) begin
      vectors++;
      if (a_rx[rx0 + k] !== exp_byte(k))
        begin miscompares++; $display("FAIL full_byte %0d: got %h required %h", k, a_rx[rx0 + k], exp_byte(k)); end
    end
    vectors++;
    if (a_done - dn0 != 1)
      begin miscompares++; $display("FAIL full_done: got %0d done cycles required 1", a_done - dn0); end
    vectors++;
    if (a_if.ram_addr !== mk_addr(0, 0, 0))
      begin miscompares++; $display("FAIL full_addr_clear: got %h required 0", a_if.ram_addr); end
    if (a_rd.size() - rd0 >= DUMP_BYTES) begin
      for (int i = 0; i < 5; i++) begin
        vectors++;
        if (a_rd[rd0 + ai[i]] !== ae[i])
          begin miscompares++; $display("FAIL read_addr %0d: got %h required %h", ai[i], a_rd[rd0 + ai[i]], ae[i]); end
      end
      vectors++;
      if (a_rd[rd0 + DUMP_BYTES - 1] !== mk_addr(PIXEL_HEIGHT - 1, PIXEL_WIDTH - 1, 0))
        begin miscompares++; $display("FAIL read_addr_last: got %h", a_rd[rd0 + DUMP_BYTES - 1]); end
      for (int k = 1; k < DUMP_BYTES; k++) begin
        vectors++;
        if (a_rdc[rd0 + k] - a_rdc[rd0 + k - 1] != 3)
          begin miscompares++; $display("FAIL spacing_l1 %0d: got %0d cycles required 3", k, a_rdc[rd0 + k] - a_rdc[rd0 + k - 1]); end
      end
    end else begin
      vectors++;
      miscompares++;
      $display("FAIL read_count: got %0d reads required %0d", a_rd.size() - rd0, DUMP_BYTES);
    end
  endtask

  task automatic test_back_pressure();
    int rx0, rd0, dn0;
    bit ok, stable;
    logic [7:0] d5;
    rx0 = a_rx.size(); rd0 = a_rd.size(); dn0 = a_done;
    a_if.tx_ready = 1'b0;
    a_if.start = 1'b1;
    tick(1);
    a_if.start = 1'b0;
    for (int k = 0; k < DUMP_BYTES; k++) begin
      wait_valid(k);
      if (k == 5) begin
        d5 = a_if.tx_data;
        stable = 1'b1;
        repeat (10) begin
          tick(1);
          if (a_if.tx_valid !== 1'b1 || a_if.tx_data !== d5 || a_if.ram_read_enable !== 1'b0) stable = 1'b0;
        end
        vectors++;
        if (d5 !== exp_byte(5))
          begin miscompares++; $display("FAIL bp_byte5: got %h required %h", d5, exp_byte(5)); end
        vectors++;
        if (!stable)
          begin miscompares++; $display("FAIL bp_stable: tx_valid=%b tx_data=%h required 1 %h", a_if.tx_valid, a_if.tx_data, d5); end
        vectors++;
        if (a_rd.size() - rd0 != 6)
          begin miscompares++; $display("FAIL bp_prefetch: got %0d reads required 6", a_rd.size() - rd0); end
      end
      a_if.tx_ready = 1'b1;
      tick(1);
      a_if.tx_ready = 1'b0;
    end
    wait_idle(1'b0, 20, ok);
    tick(1);
    vectors++;
    if (a_rx.size() - rx0 != DUMP_BYTES || a_done - dn0 != 1)
      begin miscompares++; $display("FAIL bp_totals: got %0d bytes %0d done required %0d 1", a_rx.size() - rx0, a_done - dn0, DUMP_BYTES); end
  endtask

  task automatic test_abort();
    int rx0, dn0, rx1, rd1;
    bit ok;
    rx0 = a_rx.size(); dn0 = a_done;
    a_if.tx_ready = 1'b0;
    a_if.start = 1'b1;
    tick(1);
    a_if.start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_valid(k);
      a_if.tx_ready = 1'b1;
      a_if.abort = (k == 3);
      tick(1);
      a_if.tx_ready = 1'b0;
      a_if.abort = 1'b0;
    end
    vectors++;
    if ({a_if.busy, a_if.tx_valid, a_if.done, a_if.ram_read_enable} !== 4'b0000)
      begin miscompares++; $display("FAIL abort_state: busy/valid/done/re=%b required 0000",
        {a_if.busy, a_if.tx_valid, a_if.done, a_if.ram_read_enable}); end
    tick(3);
    vectors++;
    if (a_done - dn0 != 0)
      begin miscompares++; $display("FAIL abort_done: got %0d done cycles required 0", a_done - dn0); end
    vectors++;
    if (a_rx.size() - rx0 != 3)
      begin miscompares++; $display("FAIL abort_count: got %0d bytes required 3", a_rx.size() - rx0); end
    rx1 = a_rx.size(); rd1 = a_rd.size();
    a_if.tx_ready = 1'b1;
    a_if.start = 1'b1;
    tick(1);
    a_if.start = 1'b0;
    wait_idle(1'b0, 400, ok);
    tick(1);
    vectors++;
    if (a_rx.size() - rx1 != DUMP_BYTES)
      begin miscompares++; $display("FAIL abort_restart_count: got %0d required %0d", a_rx.size() - rx1, DUMP_BYTES); end
    else begin
      vectors++;
      if (a_rx[rx1] !== exp_byte(0) || a_rd[rd1] !== mk_addr(0, 0, 1))
        begin miscompares++; $display("FAIL abort_restart_first: byte %h addr %h required %h %h",
          a_rx[rx1], a_rd[rd1], exp_byte(0), mk_addr(0, 0, 1)); end
    end
  endtask

  task automatic test_reset_mid_dump();
    int n, t, rx0, rd0;
    bit ok;
    a_if.tx_ready = 1'b1;
    a_if.start = 1'b1;
    tick(1);
    a_if.start = 1'b0;
    n = 0;
    t = 0;
    while (t < 50 && n < 3) begin
      if (a_if.ram_read_enable === 1'b1) n++;
      if (n < 3) begin tick(1); t++; end
    end
    vectors++;
    if (n != 3) begin miscompares++; $display("FAIL rst_mid_reach: got %0d strobes required 3", n); end
    tick(1);
    vectors++;
    if (a_if.tx_data !== exp_byte(1) || a_if.busy !== 1'b1)
      begin miscompares++; $display("FAIL rst_mid_pre: tx_data=%h busy=%b required %h 1", a_if.tx_data, a_if.busy, exp_byte(1)); end
    #2 reset = 1'b0;
    #1;
    vectors++;
    if ({a_if.busy, a_if.tx_valid, a_if.ram_read_enable, a_if.done} !== 4'b0000 ||
        a_if.tx_data !== 8'h00 || a_if.ram_addr !== mk_addr(0, 0, 0))
      begin miscompares++; $display("FAIL rst_mid_clear: ctrl=%b tx_data=%h addr=%h required 0000 00 0",
        {a_if.busy, a_if.tx_valid, a_if.ram_read_enable, a_if.done}, a_if.tx_data, a_if.ram_addr); end
    @(posedge clk);
    #1 reset = 1'b1;
    tick(2);
    rx0 = a_rx.size(); rd0 = a_rd.size();
    a_if.start = 1'b1;
    tick(1);
    a_if.start = 1'b0;
    wait_idle(1'b0, 400, ok);
    tick(1);
    vectors++;
    if (a_rx.size() - rx0 != DUMP_BYTES)
      begin miscompares++; $display("FAIL rst_restart_count: got %0d required %0d", a_rx.size() - rx0, DUMP_BYTES); end
    else begin
      vectors++;
      if (a_rx[rx0] !== exp_byte(0) || a_rd[rd0] !== mk_addr(0, 0, 1))
        begin miscompares++; $display("FAIL rst_restart_first: byte %h addr %h required %h %h",
          a_rx[rx0], a_rd[rd0], exp_byte(0), mk_addr(0, 0, 1)); end
    end
  endtask

  task automatic test_latency2();
    int rx0, rd0, dn0;
    bit ok;
    rx0 = b_rx.size(); rd0 = b_rdc.size(); dn0 = b_done;
    b_if.tx_ready = 1'b1;
    b_if.start = 1'b1;
    tick(1);
    b_if.start = 1'b0;
    wait_idle(1'b1, 400, ok);
    tick(1);
    vectors++;
    if (!ok || b_rx.size() - rx0 != DUMP_BYTES || b_done - dn0 != 1)
      begin miscompares++; $display("FAIL l2_totals: idle=%b bytes=%0d done=%0d required 1 %0d 1",
        ok, b_rx.size() - rx0, b_done - dn0, DUMP_BYTES); end
    for (int k = 0; k < DUMP_BYTES && k < b_rx.size() - rx0; k++) begin
      vectors++;
      if (b_rx[rx0 + k] !== exp_byte(k))
        begin miscompares++; $display("FAIL l2_byte %0d: got %h required %h", k, b_rx[rx0 + k], exp_byte(k)); end
    end
    for (int k = 1; k < DUMP_BYTES && k < b_rdc.size() - rd0; k++) begin
      vectors++;
      if (b_rdc[rd0 + k] - b_rdc[rd0 + k - 1] != 4)
        begin miscompares++; $display("FAIL spacing_l2 %0d: got %0d cycles required 4", k, b_rdc[rd0 + k] - b_rdc[rd0 + k - 1]); end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    a_if.start = 1'b0; a_if.abort = 1'b0; a_if.tx_ready = 1'b0;
    b_if.start = 1'b0; b_if.abort = 1'b0; b_if.tx_ready = 1'b0;
    test_reset();
    test_full_dump();
    test_back_pressure();
    test_abort();
    test_reset_mid_dump();
    test_latency2();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
